// File: rtl/ysyx_22040386_if_stage_if.sv
// Bundle of the fetch stage's non-clock signals: imem req/gnt/rvalid, redirect/stall, IF/ID outputs.
// Latency: none, wires only.
// Backpressure: load_use and gnt are carried here; the stage owns the master side.
interface ysyx_22040386_if_stage_if;
   logic        i_IF_jump_flag;
   logic [63:0] i_IF_jump_pc;
   logic        i_IF_load_use_flag;
   logic        o_IF_imem_req;
   logic [63:0] o_IF_imem_addr;
   logic        i_IF_imem_gnt;
   logic        i_IF_imem_rvalid;
   logic [31:0] i_IF_imem_rdata;
   logic        o_IF_valid;
   logic [31:0] o_IF_inst;
   logic [63:0] o_IF_pc;
   logic [4:0]  o_IF_rs1;
   logic [4:0]  o_IF_rs2;

   // Fetch stage side.
   modport master (
      input  i_IF_jump_flag, i_IF_jump_pc, i_IF_load_use_flag,
      input  i_IF_imem_gnt, i_IF_imem_rvalid, i_IF_imem_rdata,
      output o_IF_imem_req, o_IF_imem_addr,
      output o_IF_valid, o_IF_inst, o_IF_pc, o_IF_rs1, o_IF_rs2
   );

   // Memory / pipeline side.
   modport slave (
      output i_IF_jump_flag, i_IF_jump_pc, i_IF_load_use_flag,
      output i_IF_imem_gnt, i_IF_imem_rvalid, i_IF_imem_rdata,
      input  o_IF_imem_req, o_IF_imem_addr,
      input  o_IF_valid, o_IF_inst, o_IF_pc, o_IF_rs1, o_IF_rs2
   );
endinterface

// File: rtl/ysyx_22040386_if_stage.sv
// RV64 instruction fetch: owns PC and issues one req/gnt + rvalid fetch at a time.
// Latency: instruction is presented combinationally in the rvalid cycle; 2 cycles/inst at best.
// Backpressure: load_use parks a returned instruction in a one-entry hold buffer; jump redirects.
module ysyx_22040386_if_stage #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input logic                       i_IF_clk,
   input logic                       i_IF_rst,
   ysyx_22040386_if_stage_if.master  bus
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state;
   logic [63:0] pc;
   logic        discard;
   logic [31:0] hold_inst;

   logic        jump;
   logic        load_use;
   logic [63:0] jump_target;
   logic        fresh;
   logic        valid;
   logic [31:0] inst;

   assign jump        = bus.i_IF_jump_flag;
   assign load_use    = bus.i_IF_load_use_flag;
   assign jump_target = {bus.i_IF_jump_pc[63:2], 2'b00};

   // A response that belongs to the current PC (not one orphaned by an earlier redirect).
   assign fresh = (state == S_WAIT) && bus.i_IF_imem_rvalid && !discard;

   // Choose what the IF/ID register sees this cycle: held inst, fresh response, or a bubble.
   always_comb begin
      valid = 1'b0;
      inst  = NOP_INST;
      if (!i_IF_rst) begin
         if (state == S_HOLD) begin
            valid = 1'b1;
            inst  = hold_inst;
         end else if (fresh && !jump) begin
            valid = 1'b1;
            inst  = bus.i_IF_imem_rdata;
         end
      end
   end

   assign bus.o_IF_imem_req  = !i_IF_rst && (state == S_REQ) && !jump;
   assign bus.o_IF_imem_addr = pc;
   assign bus.o_IF_valid     = valid;
   assign bus.o_IF_inst      = inst;
   // PC is frozen while an instruction is held, so the live PC is also the held one's PC.
   assign bus.o_IF_pc        = valid ? pc : 64'd0;
   assign bus.o_IF_rs1       = valid ? inst[19:15] : 5'd0;
   assign bus.o_IF_rs2       = valid ? inst[24:20] : 5'd0;

   // Fetch sequencing: redirect beats stall everywhere; PC advances once per consumed inst.
   always_ff @(posedge i_IF_clk) begin
      if (i_IF_rst) begin
         state     <= S_REQ;
         pc        <= RESET_PC;
         discard   <= 1'b0;
         hold_inst <= 32'd0;
      end else begin
         case (state)
            S_REQ: begin
               if (jump) begin
                  pc <= jump_target;
               end else if (bus.i_IF_imem_gnt) begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.i_IF_imem_rvalid) begin
                  state <= S_REQ;
                  if (discard) begin
                     // Orphaned response retired; a redirect arriving now still takes effect.
                     discard <= 1'b0;
                     if (jump) pc <= jump_target;
                  end else if (jump) begin
                     pc <= jump_target;
                  end else if (load_use) begin
                     hold_inst <= bus.i_IF_imem_rdata;
                     state     <= S_HOLD;
                  end else begin
                     pc <= pc + 64'd4;
                  end
               end else if (jump) begin
                  // The in-flight fetch is for the old path; drop it when it lands.
                  pc      <= jump_target;
                  discard <= 1'b1;
               end
            end
            S_HOLD: begin
               if (jump) begin
                  pc    <= jump_target;
                  state <= S_REQ;
               end else if (!load_use) begin
                  pc    <= pc + 64'd4;
                  state <= S_REQ;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22040386_if_stage.sv
// Bench for the fetch stage: directed walk through the fetch scenarios, then random traffic.
// Expected outputs come from a transaction-level model plus an architectural PC scoreboard.
// Memory is modelled here with a single outstanding request and 1..3 cycle response delay.
module tb_ysyx_22040386_if_stage;

   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ysyx_22040386_if_stage_if bus ();

   ysyx_22040386_if_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
      .i_IF_clk (clk),
      .i_IF_rst (rst),
      .bus      (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Transaction-level view: is a fetch in flight, is it stale, is an inst parked.
   logic [63:0] m_pc;
   logic        m_busy, m_stale, m_held;
   logic [31:0] m_hinst;
   logic [63:0] arch_pc;     // PC the next consumed instruction must carry
   logic        rnd_mode;    // rdata comes from mem_word() so content is checkable

   // Memory side bookkeeping for random traffic.
   logic        granted;
   logic [63:0] grant_addr;
   logic        mem_pend;
   logic [63:0] mem_addr;
   int          mem_delay;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      logic [31:0] w;
      w = a[33:2] * 32'h9E37_79B1;
      return w ^ 32'h5A5A_0013;
   endfunction

   // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
   task automatic step(input logic r, input logic jmp, input logic [63:0] jt, input logic lu,
                       input logic gnt, input logic rv, input logic [31:0] rd);
      logic        e_req, e_valid, consumed;
      logic [31:0] e_inst;
      logic [63:0] jt_al;
      rst                    = r;
      bus.i_IF_jump_flag     = jmp;
      bus.i_IF_jump_pc       = jt;
      bus.i_IF_load_use_flag = lu;
      bus.i_IF_imem_gnt      = gnt;
      bus.i_IF_imem_rvalid   = rv;
      bus.i_IF_imem_rdata    = rd;
      jt_al = jt & ~64'd3;
      #4;
      e_req   = !r && !m_busy && !m_held && !jmp;
      e_valid = 1'b0;
      e_inst  = NOP_INST;
      if (!r) begin
         if (m_held) begin
            e_valid = 1'b1;
            e_inst  = m_hinst;
         end else if (m_busy && rv && !m_stale && !jmp) begin
            e_valid = 1'b1;
            e_inst  = rd;
         end
      end
      check_val("req", 64'(bus.o_IF_imem_req), 64'(e_req));
      if (e_req) check_val("addr", bus.o_IF_imem_addr, m_pc);
      check_val("valid", 64'(bus.o_IF_valid), 64'(e_valid));
      check_val("inst", 64'(bus.o_IF_inst), 64'(e_inst));
      check_val("pc", bus.o_IF_pc, e_valid ? m_pc : 64'd0);
      check_val("rs1", 64'(bus.o_IF_rs1), e_valid ? 64'((e_inst >> 15) & 32'h1F) : 64'd0);
      check_val("rs2", 64'(bus.o_IF_rs2), e_valid ? 64'((e_inst >> 20) & 32'h1F) : 64'd0);
      consumed = e_valid && !lu && !jmp;
      if (consumed) begin
         check_val("sb_pc", bus.o_IF_pc, arch_pc);
         if (rnd_mode) check_val("sb_inst", 64'(bus.o_IF_inst), 64'(mem_word(arch_pc)));
      end
      granted    = e_req && gnt;
      grant_addr = m_pc;
      @(posedge clk);
      if (r) begin
         m_pc = RESET_PC; m_busy = 1'b0; m_stale = 1'b0; m_held = 1'b0; arch_pc = RESET_PC;
      end else begin
         if (jmp)           arch_pc = jt_al;
         else if (consumed) arch_pc = arch_pc + 64'd4;
         if (m_held) begin
            if (jmp) begin
               m_held = 1'b0; m_pc = jt_al;
            end else if (!lu) begin
               m_held = 1'b0; m_pc = m_pc + 64'd4;
            end
         end else if (m_busy) begin
            if (rv) begin
               m_busy = 1'b0;
               if (m_stale) begin
                  m_stale = 1'b0;
                  if (jmp) m_pc = jt_al;
               end else if (jmp) m_pc = jt_al;
               else if (lu) begin
                  m_held = 1'b1; m_hinst = rd;
               end else m_pc = m_pc + 64'd4;
            end else if (jmp) begin
               m_pc = jt_al; m_stale = 1'b1;
            end
         end else begin
            if (jmp)      m_pc = jt_al;
            else if (gnt) m_busy = 1'b1;
         end
      end
      #1;
   endtask

   initial begin
      m_pc = RESET_PC; m_busy = 1'b0; m_stale = 1'b0; m_held = 1'b0; m_hinst = 32'd0;
      arch_pc = RESET_PC; rnd_mode = 1'b0; mem_pend = 1'b0; mem_addr = 64'd0; mem_delay = 0;
      granted = 1'b0; grant_addr = 64'd0;
      rst = 1'b1;
      bus.i_IF_jump_flag = 1'b0; bus.i_IF_jump_pc = 64'd0; bus.i_IF_load_use_flag = 1'b0;
      bus.i_IF_imem_gnt = 1'b0; bus.i_IF_imem_rvalid = 1'b0; bus.i_IF_imem_rdata = 32'd0;
      @(posedge clk); #1;

      // Reset, with a stray rvalid that must be ignored.
      step(1, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
      step(1, 0, 0, 0, 0, 0, 0);
      // First fetch: immediate grant, response next cycle.
      step(0, 0, 0, 0, 1, 0, 0);
      check_val("first_addr", bus.o_IF_imem_addr, 64'h8000_0000);
      step(0, 0, 0, 0, 0, 1, 32'h00A0_0093);
      // Grant withheld three cycles at 0x80000004.
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      // Load-use stall for two cycles coincident with the response.
      step(0, 0, 0, 1, 0, 1, 32'h0020_A183);
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      // Redirect while waiting: late response dropped, refetch at aligned target.
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 1, 64'h8000_0102, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 32'h1111_1111);
      step(0, 0, 0, 0, 1, 0, 0);
      check_val("redirect_addr", bus.o_IF_imem_addr, 64'h8000_0100);
      // Jump and load-use together while holding; then jump alongside grant.
      step(0, 0, 0, 1, 0, 1, 32'h0031_0233);
      step(0, 1, 64'h8000_0200, 1, 0, 0, 0);
      step(0, 1, 64'h8000_0300, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      // Reset while holding.
      step(0, 0, 0, 1, 0, 1, 32'h0041_8293);
      step(1, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);

      // Random traffic against the memory model.
      rnd_mode = 1'b1;
      step(1, 0, 0, 0, 0, 0, 0);
      mem_pend = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         logic        r, jmp, lu, gnt, rv;
         logic [63:0] jt;
         logic [31:0] rd;
         r   = ($urandom_range(0, 299) == 0);
         jmp = ($urandom_range(0, 11) == 0);
         jt  = 64'h8000_0000 + 64'($urandom_range(0, 4095));
         lu  = ($urandom_range(0, 3) == 0);
         gnt = ($urandom_range(0, 2) != 0);
         rv  = 1'b0;
         rd  = $urandom;
         if (mem_pend) begin
            if (mem_delay == 0) begin
               rv = 1'b1;
               rd = mem_word(mem_addr);
            end else begin
               mem_delay--;
            end
         end
         step(r, jmp, jt, lu, gnt, rv, rd);
         if (r || rv) mem_pend = 1'b0;
         if (!r && granted) begin
            mem_pend  = 1'b1;
            mem_addr  = grant_addr;
            mem_delay = $urandom_range(0, 2);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
